// File: rtl/display_scan_controller_if.sv
// display_scan_controller_if: control inputs and shared seven-segment pins of the scan controller
interface display_scan_controller_if;
    logic        start;
    logic        clear;
    logic [27:0] op_segs;
    logic [27:0] result_segs;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        phase;
    logic        busy;

    modport master (
        output start, clear, op_segs, result_segs,
        input  seg, an, phase, busy
    );

    modport slave (
        input  start, clear, op_segs, result_segs,
        output seg, an, phase, busy
    );
endinterface

// File: rtl/display_scan_controller.sv
// display_scan_controller: shows the latched operation name for OP_FRAMES frames, then the latched result
module display_scan_controller #(
    parameter int REFRESH_DIV = 100000,
    parameter int OP_FRAMES   = 250
) (
    input logic clk,
    input logic reset,
    display_scan_controller_if.slave bus
);
    localparam int DW = $clog2(REFRESH_DIV);
    localparam int FW = $clog2(OP_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, SHOW_OP, SHOW_RESULT} state_t;

    state_t      state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]  idx_q, idx_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [27:0] op_q, op_d, res_q, res_d, shown;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        phase_q, phase_d, busy_q, busy_d;

    // Next state, counters and the pin values for that next state, so pins change with the digit index
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        op_d    = op_q;
        res_d   = res_q;
        if (bus.clear) begin
            state_d = IDLE;
            div_d   = '0;
            idx_d   = '0;
            frame_d = '0;
        end else if (bus.start) begin
            state_d = SHOW_OP;
            div_d   = '0;
            idx_d   = '0;
            frame_d = '0;
            op_d    = bus.op_segs;
            res_d   = bus.result_segs;
        end else if (state_q != IDLE) begin
            if (div_q == DW'(REFRESH_DIV - 1)) begin
                div_d = '0;
                idx_d = idx_q + 2'd1;
                if (state_q == SHOW_OP && idx_q == 2'd3) begin
                    frame_d = frame_q + 1'b1;
                    state_d = (frame_d == FW'(OP_FRAMES)) ? SHOW_RESULT : SHOW_OP;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
        shown   = (state_d == SHOW_RESULT) ? res_d : op_d;
        seg_d   = (state_d == IDLE) ? 7'h7F : shown[7*idx_d +: 7];
        an_d    = (state_d == IDLE) ? 4'hF : ~(4'b0001 << idx_d);
        phase_d = (state_d == SHOW_RESULT);
        busy_d  = (state_d == SHOW_OP);
    end

    // Register state, counters, latched buses and all pin drives
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            op_q    <= '0;
            res_q   <= '0;
            seg_q   <= 7'h7F;
            an_q    <= 4'hF;
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            op_q    <= op_d;
            res_q   <= res_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
    assign bus.phase = phase_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: directed scoreboard bench for the display scan controller
module tb_display_scan_controller;
    localparam int R   = 4;
    localparam int F   = 2;
    localparam int OPN = 4 * R * F;

    typedef struct {
        string      name;
        logic [6:0] seg;
        logic [3:0] an;
        logic       phase;
        logic       busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    display_scan_controller_if bus();

    display_scan_controller #(.REFRESH_DIV(R), .OP_FRAMES(F)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    function automatic exp_t mk(string nm, logic [6:0] s, logic [3:0] a, logic p, logic b);
        exp_t e;
        e.name = nm; e.seg = s; e.an = a; e.phase = p; e.busy = b;
        return e;
    endfunction

    function automatic exp_t idle(string nm);
        return mk(nm, 7'h7F, 4'hF, 1'b0, 1'b0);
    endfunction

    // k = output cycle counted from the edge that sampled start (k=1 is the first displayed cycle)
    function automatic exp_t scan(string nm, logic [27:0] op, logic [27:0] res, int k);
        logic [27:0] v;
        logic [3:0]  a;
        logic        ph;
        int          d;
        ph = (k > OPN);
        d  = (((ph ? k - OPN : k) - 1) / R) % 4;
        v  = ph ? res : op;
        a  = 4'hF;
        a[d] = 1'b0;
        return mk(nm, v[7*d +: 7], a, ph, !ph);
    endfunction

    task automatic step(input exp_t e);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_seq(input string nm, input logic [27:0] op, input logic [27:0] res, input int n, input bit noise);
        bus.op_segs = op;
        bus.result_segs = res;
        bus.start = 1'b1;
        for (int k = 1; k <= n; k++) begin
            step(scan(nm, op, res, k));
            bus.start = 1'b0;
            if (noise) begin
                bus.op_segs = 28'($urandom);
                bus.result_segs = 28'($urandom);
            end
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (bus.seg !== e.seg || bus.an !== e.an || bus.phase !== e.phase || bus.busy !== e.busy) begin
                    fails++;
                    $display("FAIL %s t=%0t: got seg=%h an=%b phase=%b busy=%b, want seg=%h an=%b phase=%b busy=%b",
                             e.name, $time, bus.seg, bus.an, bus.phase, bus.busy, e.seg, e.an, e.phase, e.busy);
                end
            end
        end
    end

    initial begin
        exp_t e;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.clear = 1'b0;
        bus.op_segs = '0;
        bus.result_segs = '0;
        repeat (3) step(idle("reset"));
        reset = 1'b0;
        repeat (4) step(idle("idle_no_start"));

        bus.op_segs = 28'h0123456;
        bus.result_segs = 28'hABCDEF0;
        bus.start = 1'b1;
        step(mk("op_digit0", 7'h56, 4'b1110, 1'b0, 1'b1));
        bus.start = 1'b0;
        for (int k = 2; k <= OPN + 16; k++) begin
            e = scan("op_scan", 28'h0123456, 28'hABCDEF0, k);
            if (k == 5) e = mk("op_digit1", 7'h68, 4'b1101, 1'b0, 1'b1);
            if (k == OPN + 1) e = mk("result_digit0", 7'h70, 4'b1110, 1'b1, 1'b0);
            step(e);
        end

        run_seq("latching", 28'h1234567, 28'h7654321, OPN + 20, 1'b1);

        run_seq("restart_first", 28'h5A5A5A5, 28'h0F0F0F0, 20, 1'b0);
        run_seq("restart_second", 28'h2468ACE, 28'h13579BD, OPN + 12, 1'b0);

        run_seq("pre_clear", 28'h3C3C3C3, 28'h6E6E6E6, 10, 1'b0);
        bus.clear = 1'b1;
        step(idle("clear"));
        bus.clear = 1'b0;
        repeat (3) step(idle("after_clear"));
        bus.clear = 1'b1;
        bus.start = 1'b1;
        bus.op_segs = 28'h1111111;
        step(idle("clear_and_start"));
        bus.clear = 1'b0;
        bus.start = 1'b0;
        repeat (6) step(idle("after_clear_start"));

        run_seq("pre_reset", 28'h0A0B0C0, 28'hFEDCBA9, OPN + 2 * R + 2, 1'b0);
        reset = 1'b1;
        step(idle("reset_mid_scan"));
        reset = 1'b0;
        repeat (2) step(idle("after_reset"));
        run_seq("post_reset", 28'h7777000, 28'h0001234, OPN + 8, 1'b0);

        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Time-multiplexed scan controller for the four-digit seven-segment display. On each new calculator result it shows the four-letter operation name (Add / SUb / MUL from the operation decoder) for a fixed number of refresh frames. It then switches to the four result digits and holds them until the next result or a clear. It sits between the operation/number segment decoders and the board's shared segment and anode pins, and it is the only driver of those pins.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays enabled; legal range ≥ 2.
- `OP_FRAMES`, default 250: full 4-digit frames the operation name is shown; legal range ≥ 1.

- `clk`, input, 1 bit: the single clock. All logic is on the rising edge.
- `reset`, input, 1 bit: synchronous, active-high.
- `start`, input, 1 bit: one-cycle pulse; latch both segment buses and begin the operation-name phase.
- `clear`, input, 1 bit: synchronous request to blank the display and return to IDLE.
- `op_segs`, input, 28 bits: operation letters, active-low. [6:0] is digit 0 (rightmost) … [27:21] is digit 3.
- `result_segs`, input, 28 bits: result digits, same packing and polarity.
- `seg`, output, 7 bits: active-low segment drive, bit 0 = segment a.
- `an`, output, 4 bits: active-low digit enables, an[0] = digit 0.
- `phase`, output, 1 bit: 0 = IDLE or operation name, 1 = result.
- `busy`, output, 1 bit: high while in SHOW_OP.

## Operation
- States: IDLE, SHOW_OP, SHOW_RESULT. All outputs are registered.
- IDLE: `seg`=7'h7F, `an`=4'hF, `phase`=0, `busy`=0.
- `start` in any state:
  - Latch `op_segs` and `result_segs` into internal 28-bit registers.
  - Clear the divider, digit index and frame counter; enter SHOW_OP.
  - A `start` during SHOW_OP or SHOW_RESULT restarts the sequence with the new data.
- Divider counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and advances the digit index 0→1→2→3→0.
- Digit index wrap 3→0 ends one frame.
- SHOW_OP:
  - `an` = one-hot-low of the digit index (digit 0 → 4'b1110).
  - `seg` = latched op bits for that digit.
  - `busy`=1, `phase`=0.
  - Frame counter increments at each frame end. When it reaches OP_FRAMES, go to SHOW_RESULT with digit index 0 and divider 0.
- SHOW_RESULT: same scan, using the latched result bits. `phase`=1, `busy`=0. Stays here indefinitely.
- Live input changes are ignored; only the values latched at `start` are displayed.
- `clear`: go to IDLE. `clear` and `start` in the same cycle: `clear` wins and nothing is latched.
- `reset`:
  - Priority over everything.
  - Forces IDLE and zeroes all counters and latched buses. Outputs show their IDLE values on the following cycle.
  - Mid-scan reset is legal and takes effect immediately.
- Counter widths:
  - Divider: $clog2(REFRESH_DIV).
  - Frame counter: $clog2(OP_FRAMES+1).
  - Counters never overflow; each wraps or stops exactly as stated above.

## Timing
- Let `start` be sampled at edge T.
- Op digit 0 is driven from edge T+1 for REFRESH_DIV cycles, then digit 1, 2, 3.
- Operation phase lasts exactly 4·REFRESH_DIV·OP_FRAMES cycles. Result digit 0 appears at edge T+1+4·REFRESH_DIV·OP_FRAMES.
- `clear` or `reset` at edge T: IDLE values from T+1.
- `an` never has more than one bit low. `an` and `seg` change on the same edge, so there is no ghost cycle where a new digit is enabled with the previous digit's segments.

## Test plan
- Reset check (REFRESH_DIV=4, OP_FRAMES=2): hold `reset` 3 cycles → `seg`=7'h7F, `an`=4'hF, `phase`=0, `busy`=0 thereafter with no `start`.
- Op display (same params):
  - Stimulus: `op_segs`=28'h0123456, `result_segs`=28'hABCDEF0, `start` at T.
  - T+1..T+4: `an`=1110, `seg`=7'h56.
  - T+5..T+8: `an`=1101, `seg`=7'h68 (bits [13:7] of 28'h0123456).
  - `busy`=1 through T+32.
  - T+33: `an`=1110, `seg`=7'h70, `phase`=1, `busy`=0.
- Data latching: change `op_segs` and `result_segs` every cycle after `start` → displayed values remain those sampled at `start`.
- Restart: second `start` at T+20 with new data → op digit 0 of new data from T+21, result phase at T+53.
- Clear: `clear` at T+10 → IDLE outputs at T+11. `clear`+`start` together → stays IDLE, `busy`=0.
- Reset mid-scan: `reset` during SHOW_RESULT digit 2 → IDLE next cycle. Following `start` begins at digit 0 with a full op phase.
